// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution,
// a shift-add multiplier that stalls the front end, and the EX/MEM register.
//
// Flow control: stallE is the only handshake. While stallE=1 the front end
// holds PC, IF/ID and ID/EX, and EX/MEM loads a bubble (control bits cleared,
// data fields held). When stallE=0 the instruction in EX retires into EX/MEM
// on the next rising edge.
module execute_stage #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validE,
  input  logic             regwriteE,
  input  logic             memwriteE,
  input  logic             isloadE,
  input  logic             alusrcE,
  input  logic             isbranchE,
  input  logic             isjumpE,
  input  logic             isjalrE,
  input  logic [3:0]       alucontrolE,
  input  logic [2:0]       branchtypeE,
  input  logic [WIDTH-1:0] rd1E,
  input  logic [WIDTH-1:0] rd2E,
  input  logic [WIDTH-1:0] immE,
  input  logic [WIDTH-1:0] pcE,
  input  logic [4:0]       rdE,
  input  logic [1:0]       forwardaE,
  input  logic [1:0]       forwardbE,
  input  logic [WIDTH-1:0] resultW,
  input  logic [WIDTH-1:0] readdataW,
  output logic             isbranchtakenE,
  output logic [WIDTH-1:0] branchtargetE,
  output logic             stallE,
  output logic [WIDTH-1:0] aluresultM,
  output logic [WIDTH-1:0] writedataM,
  output logic [WIDTH-1:0] pcplus4M,
  output logic [4:0]       rdM,
  output logic             validM,
  output logic             regwriteM,
  output logic             memwriteM,
  output logic             isloadM,
  output logic [1:0]       mul_state_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(MUL_CYCLES + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_PASB = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mul_state_e;

  mul_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] alu_out_d;
  logic [WIDTH-1:0] pc_plus4;
  logic             br_cond;
  logic             is_mul;

  assign is_mul      = (alucontrolE == OP_MUL);
  assign pc_plus4    = pcE + WIDTH'(4);
  assign alu_b       = alusrcE ? immE : fwd_b;
  assign mul_state_o = state_q;

  // Operand forwarding muxes for source A and forwarded B
  always_comb begin
    src_a = rd1E;
    unique case (forwardaE)
      2'b00: src_a = rd1E;
      2'b01: src_a = resultW;
      2'b10: src_a = aluresultM;
      default: src_a = readdataW;
    endcase
    fwd_b = rd2E;
    unique case (forwardbE)
      2'b00: fwd_b = rd2E;
      2'b01: fwd_b = resultW;
      2'b10: fwd_b = aluresultM;
      default: fwd_b = readdataW;
    endcase
  end

  // ALU; a multiply only retires from DONE, where the accumulator holds the product
  always_comb begin
    alu_res = src_a + alu_b;
    case (alucontrolE)
      OP_ADD:  alu_res = src_a + alu_b;
      OP_SUB:  alu_res = src_a - alu_b;
      OP_AND:  alu_res = src_a & alu_b;
      OP_OR:   alu_res = src_a | alu_b;
      OP_XOR:  alu_res = src_a ^ alu_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(alu_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < alu_b)};
      OP_SLL:  alu_res = src_a << alu_b[SHW-1:0];
      OP_SRL:  alu_res = src_a >> alu_b[SHW-1:0];
      OP_SRA:  alu_res = WIDTH'($signed(src_a) >>> alu_b[SHW-1:0]);
      OP_PASB: alu_res = alu_b;
      OP_MUL:  alu_res = acc_q;
      default: alu_res = src_a + alu_b;
    endcase
    alu_out_d = isjumpE ? pc_plus4 : alu_res;
  end

  // Branch condition (A against forwarded B) and redirect target
  always_comb begin
    br_cond = 1'b0;
    case (branchtypeE)
      3'd0: br_cond = (src_a == fwd_b);
      3'd1: br_cond = (src_a != fwd_b);
      3'd4: br_cond = ($signed(src_a) <  $signed(fwd_b));
      3'd5: br_cond = ($signed(src_a) >= $signed(fwd_b));
      3'd6: br_cond = (src_a <  fwd_b);
      3'd7: br_cond = (src_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
    isbranchtakenE = validE & ((isbranchE & br_cond) | isjumpE);
    branchtargetE  = isjalrE ? ((src_a + immE) & ~WIDTH'(1)) : (pcE + immE);
    // Gated by rst so the hazard unit sees no stall while reset is asserted
    stallE = rst & validE & is_mul & (state_q != S_DONE);
  end

  // Multiplier FSM: latch operands, shift-add for MUL_CYCLES iterations, then hand off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (validE && is_mul) begin
            mcand_q  <= src_a;
            mplier_q <= alu_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mcand_q[0]) acc_q <= acc_q + mplier_q;
          mplier_q <= mplier_q << 1;
          mcand_q  <= mcand_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(MUL_CYCLES - 1)) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // EX/MEM register: bubble while stalled, invalid instructions carry no control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aluresultM <= '0;
      writedataM <= '0;
      pcplus4M   <= '0;
      rdM        <= '0;
      validM     <= 1'b0;
      regwriteM  <= 1'b0;
      memwriteM  <= 1'b0;
      isloadM    <= 1'b0;
    end else if (stallE) begin
      validM    <= 1'b0;
      regwriteM <= 1'b0;
      memwriteM <= 1'b0;
      isloadM   <= 1'b0;
    end else begin
      aluresultM <= alu_out_d;
      writedataM <= fwd_b;
      pcplus4M   <= pc_plus4;
      rdM        <= rdE;
      validM     <= validE;
      regwriteM  <= validE & regwriteE;
      memwriteM  <= validE & memwriteE;
      isloadM    <= validE & isloadE;
    end
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the 5-stage MIPS-style pipeline, directly downstream of the forwarding/hazard unit. Selects forwarded operands using `forwardaE`/`forwardbE`, runs the ALU, and resolves branches/jumps. It returns `isbranchtakenE` and `branchtargetE` to the hazard unit. It also owns the EX/MEM pipeline register and a 32-cycle iterative multiplier that stalls the front end while busy.

## Interface
- `WIDTH`, 32: datapath width
- `MUL_CYCLES`, 32: multiplier iteration count; equals `WIDTH`
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-low reset (0 = reset)
- `validE`, `regwriteE`, `memwriteE`, `isloadE`, `alusrcE`, `isbranchE`, `isjumpE`, `isjalrE` in 1 each: ID/EX control bits
- `alucontrolE` in 4: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 passB (lui), 11 mul; other codes = add
- `branchtypeE` in 3: 0 beq, 1 bne, 4 blt, 5 bge, 6 bltu, 7 bgeu; 2, 3 never taken
- `rd1E`, `rd2E`, `immE`, `pcE` in 32 each: register-file operands, immediate, instruction PC
- `rdE` in 5: destination register
- `forwardaE`, `forwardbE` in 2 each: 00 register file, 01 `resultW`, 10 `aluresultM`, 11 `readdataW`
- `resultW`, `readdataW` in 32 each: writeback ALU result, writeback load data
- `isbranchtakenE` out 1, `branchtargetE` out 32: combinational, to the hazard unit
- `stallE` out 1: combinational; holds PC, IF/ID and ID/EX
- `aluresultM`, `writedataM`, `pcplus4M` out 32 each: EX/MEM register outputs
- `rdM` out 5
- `validM`, `regwriteM`, `memwriteM`, `isloadM` out 1 each

## Operation
- Source A = mux(`forwardaE`) over `rd1E` / `resultW` / `aluresultM` / `readdataW`.
- Forwarded B = same mux on `forwardbE` with `rd2E` as the 00 source.
- ALU B = `immE` when `alusrcE`, else forwarded B.
- `writedataM` captures forwarded B, never the immediate.
- Shifts use B[4:0]. slt is signed compare, sltu is unsigned. Result is 32'h0000_0001 or 0.
- Arithmetic wraps modulo 2^32. mul returns the low 32 bits of the product (sign-agnostic).
- Branch condition compares A with forwarded B.
- `isbranchtakenE` = `validE` & ((`isbranchE` & cond) | `isjumpE`).
- `branchtargetE`: when `isjalrE`, (A + `immE`) & ~1; otherwise `pcE` + `immE`.
- For jumps, `aluresultM` gets `pcE` + 4. `pcplus4M` always gets `pcE` + 4.
- Multiplier FSM states:
  - IDLE. When `validE` & op=mul: latch A and B into internal registers, clear the accumulator, counter ← 0, go to BUSY.
  - BUSY. Each cycle: if mcand bit0, acc += mplier; mplier <<= 1; mcand >>= 1; counter++. After `MUL_CYCLES` iterations, go to DONE.
  - DONE. EX/MEM captures acc; go to IDLE.
- `stallE` = `validE` & op=mul & (state != DONE).
- Stall behaviour:
  - Every cycle `stallE`=1, EX/MEM loads a bubble: `validM`, `regwriteM`, `memwriteM`, `isloadM` = 0; data fields don't-care but held.
  - Forwarded values are ignored while BUSY; the latched operands are used.
- Control outputs with `validE`=0 are forced to 0 in EX/MEM.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - all EX/MEM outputs to 0
  - FSM to IDLE, counter and accumulator to 0
  - `stallE`=0
- Reset mid-multiply aborts it; no result is written.
- Non-mul ops: 1-cycle latency. Inputs at edge N appear on the M outputs after edge N+1.
- mul in EX at cycle T:
  - `stallE`=1 for cycles T..T+`MUL_CYCLES`.
  - `stallE`=0 at T+`MUL_CYCLES`+1 (DONE).
  - Product visible on `aluresultM` with `validM`=1 after that edge.
  - Total EX occupancy is `MUL_CYCLES`+2 cycles.
- Back-to-back muls: DONE → IDLE, then the next mul starts in the following cycle with no extra bubble beyond IDLE.
- `isbranchtakenE`/`branchtargetE` are combinational, valid in the same cycle; the hazard unit decides the flush.
- A branch is never in EX concurrently with BUSY, because stall holds ID/EX.

## Test plan
- Reset: assert `rst`=0 mid-operation → all outputs 0 and `stallE`=0 immediately. Release → first add of 3+4 gives `aluresultM`=7 one cycle later.
- Forwarding: `rd1E`=1, `resultW`=2, `aluresultM`=3, `readdataW`=4. Add with B=0 and `forwardaE`=00/01/10/11 → 1/2/3/4. `forwardbE`=10 with `alusrcE`=0 → `writedataM`=3.
- Branches:
  - beq with A=B=5, `pcE`=0x100, `immE`=0x20 → taken, target 0x120.
  - bltu with A=0xFFFFFFFF, B=1 → not taken; blt with the same operands → taken.
  - jalr with A=0x203, `immE`=0 → target 0x202, `aluresultM`=`pcE`+4.
- mul: 0x0001_0003 × 0x0002_0005 → `stallE` high 33 cycles, 33 bubbles in M, then `aluresultM`=0x000B_000F with `validM`=1. -1 × 7 → 0xFFFF_FFF9.
- Operand latch: change `aluresultM`/`forwardaE` sources during BUSY → product unchanged.
- Reset at BUSY iteration 10 → state IDLE, no `validM`. Reissue → correct product after a full 34 cycles.
